// File: rtl/inst_cache_ctrl.sv
// inst_cache_ctrl: direct-mapped instruction cache controller (tag/valid array, data RAM sequencing, line refill)
// Ports: clk/reset (sync, active-high); CPU fetch side inst_req/inst_addr -> inst_addr_ok/inst_data_ok/inst_rdata;
// data RAM side data_en/data_wen/data_index/data_offset/data_wdata <- data_rdata (1-cycle read latency);
// AXI read bridge side rd_req/rd_addr <- rd_addr_ok, ret_valid/ret_last/ret_data.
// Optional macro INST_CACHE_FLUSH_EN adds inst_flush: clears all valid bits when sampled in IDLE.
module inst_cache_ctrl #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef INST_CACHE_FLUSH_EN
  input  logic                    inst_flush,
`endif
  input  logic                    inst_req,
  input  logic [31:0]             inst_addr,
  output logic                    inst_addr_ok,
  output logic                    inst_data_ok,
  output logic [31:0]             inst_rdata,
  output logic                    data_en,
  output logic [31:0]             data_wen,
  output logic [INDEX_WIDTH-1:0]  data_index,
  output logic [OFFSET_WIDTH-1:0] data_offset,
  output logic [255:0]            data_wdata,
  input  logic [31:0]             data_rdata,
  output logic                    rd_req,
  output logic [31:0]             rd_addr,
  input  logic                    rd_addr_ok,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [31:0]             ret_data
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, WRITE} state_t;
  localparam int LINES = 2 ** INDEX_WIDTH;
  state_t r_state, w_next;
  logic [31:0] r_addr;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [TAG_WIDTH-1:0] r_tags [LINES];
  logic [LINES-1:0] r_valid;
  logic r_vq;
  logic [2:0] r_cnt;
  // packed with word 0 leftmost so the whole buffer is the refill line, word 0 in the MSBs
  logic [0:7][31:0] r_line;
  logic w_hit, w_flush, w_last, w_write, w_addr_ok, w_accept, w_unused;
  logic [INDEX_WIDTH-1:0] w_idx_in, w_idx_q;

  assign w_idx_in  = inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_idx_q   = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_hit     = r_state == LOOKUP && r_vq && r_tag == r_addr[31 -: TAG_WIDTH];
`ifdef INST_CACHE_FLUSH_EN
  assign w_flush   = r_state == IDLE && inst_flush;
`else
  assign w_flush   = 1'b0;
`endif
  assign w_last    = r_state == REFILL && ret_valid && &r_cnt;
  assign w_write   = r_state == WRITE;
  // a hit in LOOKUP frees the pipeline exactly like IDLE, so a new request can be taken the same cycle
  assign w_addr_ok = !reset && !w_flush && (r_state == IDLE || w_hit);
  assign w_accept  = inst_req && w_addr_ok;
  assign w_unused  = ret_last;

  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;

  always_comb begin
    w_next = (r_state == IDLE || w_hit) ? (w_accept ? LOOKUP : IDLE) :
             r_state == LOOKUP ? MISS :
             r_state == MISS   ? (rd_addr_ok ? REFILL : MISS) :
             r_state == REFILL ? (w_last ? WRITE : REFILL) : IDLE;
  end

  always_comb begin
    inst_addr_ok = w_addr_ok;
    inst_data_ok = !reset && (w_hit || w_write);
    inst_rdata   = reset ? '0 : w_hit ? data_rdata : w_write ? r_line[r_addr[4:2]] : '0;
    data_en      = !reset && (w_accept || w_write);
    data_wen     = (!reset && w_write) ? '1 : '0;
    data_index   = w_write ? w_idx_q : w_idx_in;
    data_offset  = w_write ? r_addr[OFFSET_WIDTH-1:0] : inst_addr[OFFSET_WIDTH-1:0];
    rd_req       = !reset && r_state == MISS;
    rd_addr      = rd_req ? {r_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;
  end

  assign data_wdata = r_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_flush) r_valid <= '0;
      if (w_accept) begin
        r_addr <= inst_addr;
        r_tag  <= r_tags[w_idx_in];
        r_vq   <= r_valid[w_idx_in];
      end
      if (r_state == MISS && rd_addr_ok) r_cnt <= '0;
      if (r_state == REFILL && ret_valid) begin
        r_line[r_cnt] <= ret_data;
        r_cnt         <= r_cnt + 3'd1;
      end
      if (w_write) begin
        r_tags[w_idx_q]  <= r_addr[31 -: TAG_WIDTH];
        r_valid[w_idx_q] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_cache_ctrl.sv
// tb_inst_cache_ctrl: randomized and directed check of inst_cache_ctrl against a behavioural cache model
module tb_inst_cache_ctrl;
  logic clk = 0, reset = 1, inst_req = 0, inst_flush = 0;
  logic rd_addr_ok = 0, ret_valid = 0, ret_last = 0;
  logic [31:0] inst_addr = 0, ret_data = 0, data_rdata = 0;
  logic inst_addr_ok, inst_data_ok, data_en, rd_req;
  logic [31:0] inst_rdata, data_wen, rd_addr;
  logic [6:0] data_index;
  logic [4:0] data_offset;
  logic [255:0] data_wdata;
  int tests = 0, fails = 0, cyc = 0, n_refill = 0;
  bit mv [128];
  logic [19:0] mt [128];
  logic [255:0] ram [128];
  int q_due[$];
  logic [31:0] q_dat[$];
  bit q_ism[$];
  bit miss_pend = 0, br_done = 0, accepted = 0, auto_cpu = 0;
  logic [31:0] miss_addr = 0;
  int br_st = 0, br_beat = 0;
  bit ram_en, ram_we;
  logic [6:0] ram_idx;
  logic [2:0] ram_w;
  logic [255:0] ram_wd;

  always #5 clk = ~clk;

  inst_cache_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef INST_CACHE_FLUSH_EN
    .inst_flush(inst_flush),
`endif
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_index(data_index), .data_offset(data_offset),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_addr_ok(rd_addr_ok),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(logic [31:0] a);
    return a[31:5] == 27'h80 ? 32'hA0 + {29'd0, a[4:2]} : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [255:0] line_of(logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[255 - 32*k -: 32] = mem(base + 32'(4*k));
    return l;
  endfunction

  task automatic sample();
    logic [6:0] idx;
    bit hit;
    @(negedge clk);
    cyc++;
    accepted = 0;
    ram_en = data_en; ram_we = data_wen != 0; ram_idx = data_index; ram_w = data_offset[4:2]; ram_wd = data_wdata;
    if (reset) begin
      check("reset_outputs", {inst_addr_ok, inst_data_ok, data_en, rd_req, data_wen, rd_addr, inst_rdata}, '0);
      mv = '{default: 0};
      q_due.delete(); q_dat.delete(); q_ism.delete();
      miss_pend = 0; br_done = 0; br_st = 0;
      return;
    end
    check("addr_ok", inst_addr_ok, !miss_pend && !inst_flush);
    if (inst_flush && !miss_pend && q_due.size() == 0) mv = '{default: 0};
    if (rd_req) begin
      check("rd_req_when_miss", miss_pend && br_st < 2 && !br_done, 1);
      check("rd_addr", rd_addr, miss_addr);
    end
    if (data_wen != 0) begin
      check("write_after_refill", miss_pend && br_done, 1);
      check("write_en", data_en, 1);
      check("data_wen", data_wen, 32'hFFFF_FFFF);
      check("data_wdata", data_wdata, line_of(miss_addr));
    end
    if (br_st == 1 && rd_req && rd_addr_ok) begin
      br_st = 2; br_beat = 0; n_refill++;
    end else if (br_st == 2 && ret_valid) begin
      br_beat++;
      if (br_beat == 8) begin
        br_st = 0; br_done = 1;
        if (q_due.size() > 0) q_due[0] = cyc + 1;
      end
    end
    if (br_st == 0 && rd_req && !br_done) br_st = 1;
    if (inst_data_ok || (q_due.size() > 0 && q_due[0] == cyc)) begin
      if (q_due.size() == 0) check("data_ok_unexpected", inst_data_ok, 0);
      else begin
        check("data_ok_timing", inst_data_ok, q_due[0] == cyc);
        if (inst_data_ok) check("inst_rdata", inst_rdata, q_dat[0]);
        if (q_ism[0]) miss_pend = 0;
        void'(q_due.pop_front()); void'(q_dat.pop_front()); void'(q_ism.pop_front());
      end
    end
    if (inst_req && inst_addr_ok) begin
      accepted = 1;
      idx = inst_addr[11:5];
      hit = mv[idx] && mt[idx] == inst_addr[31:12];
      q_dat.push_back(mem(inst_addr));
      q_due.push_back(hit ? cyc + 1 : 0);
      q_ism.push_back(!hit);
      if (!hit) begin
        miss_pend = 1; br_done = 0; miss_addr = {inst_addr[31:5], 5'b0};
        mv[idx] = 1; mt[idx] = inst_addr[31:12];
      end
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    if (ram_en) begin
      if (ram_we) ram[ram_idx] = ram_wd;
      data_rdata = ram[ram_idx][255 - 32*int'(ram_w) -: 32];
    end
    rd_addr_ok = !reset && br_st == 1 && $urandom_range(0, 2) == 0;
    ret_valid  = !reset && (br_st == 2 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 7) == 0);
    ret_last   = ret_valid && br_st == 2 && br_beat == 7;
    ret_data   = (ret_valid && br_st == 2) ? mem(miss_addr + 32'(4*br_beat)) : $urandom;
    if (auto_cpu && (accepted || !inst_req)) begin
      inst_req  = $urandom_range(0, 3) != 0;
      inst_addr = {20'($urandom_range(1, 3)), 7'($urandom_range(0, 3) * 42), 3'($urandom), 2'b00};
    end
  endtask

  task automatic cycle();
    sample();
    drive();
  endtask

  task automatic request(logic [31:0] a);
    int n = 0;
    inst_req = 1; inst_addr = a;
    do begin cycle(); n++; end while (!accepted && n < 100);
    check("request_accepted", accepted, 1);
    inst_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_due.size() > 0 || miss_pend) && n < 300) begin cycle(); n++; end
    check("idle_reached", q_due.size() == 0 && !miss_pend, 1);
  endtask

  initial begin
    int n0, n;
    logic [31:0] b2b [3] = '{32'h1000, 32'h1004, 32'h1008};
    for (int i = 0; i < 128; i++) ram[i] = '0;
    repeat (3) cycle();
    reset = 0;
    n0 = n_refill; request(32'h1004); wait_idle();
    check("first_miss_refills", n_refill - n0, 1);
    n0 = n_refill; request(32'h101C); wait_idle();
    check("hit_no_refill", n_refill - n0, 0);
    inst_req = 1;
    foreach (b2b[i]) begin
      inst_addr = b2b[i];
      cycle();
      check("b2b_accept", accepted, 1);
    end
    inst_req = 0; wait_idle();
    n0 = n_refill; request(32'h2004); wait_idle(); request(32'h1004); wait_idle();
    check("conflict_refills", n_refill - n0, 2);
    request(32'h3008);
    n = 0;
    while (!(br_st == 2 && br_beat == 3) && n < 200) begin cycle(); n++; end
    check("reached_beat3", br_st == 2 && br_beat == 3, 1);
    reset = 1; repeat (2) cycle(); reset = 0;
    n0 = n_refill; request(32'h3008); wait_idle();
    check("miss_after_abort", n_refill - n0, 1);
`ifdef INST_CACHE_FLUSH_EN
    request(32'h1000); wait_idle();
    inst_flush = 1; cycle(); inst_flush = 0;
    n0 = n_refill; request(32'h1000); wait_idle();
    check("miss_after_flush", n_refill - n0, 1);
`endif
    auto_cpu = 1;
    repeat (4000) cycle();
    auto_cpu = 0; inst_req = 0;
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
